// File: rtl/nv_nvdla_sdp_pkg.sv
// Shared SDP definitions: atom geometry, egress FSM states and packed-mask helpers.
package nv_nvdla_sdp_pkg;

   localparam int unsigned ATOM_W = 64;
   localparam int unsigned ATOMS  = 4;
   localparam int unsigned CNT_W  = 13;
   localparam int unsigned IDX_W  = $clog2(ATOMS);
   localparam int unsigned DATA_W = ATOMS * ATOM_W;
   localparam int unsigned IN_W   = DATA_W + ATOMS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } eg_state_t;

   function automatic logic [IDX_W:0] mask_cnt(input logic [ATOMS-1:0] m);
      logic [IDX_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < int'(ATOMS); i++) begin
         cnt = cnt + (IDX_W+1)'(m[i]);
      end
      return cnt;
   endfunction

   // A legal mask is a non-empty run of ones starting at bit 0.
   function automatic logic mask_legal(input logic [ATOMS-1:0] m);
      logic [ATOMS:0] ones;
      ones = ((ATOMS+1)'(1) << mask_cnt(m)) - (ATOMS+1)'(1);
      return (m != '0) && (m == ones[ATOMS-1:0]);
   endfunction

   function automatic logic [IDX_W-1:0] lsb_idx(input logic [ATOMS-1:0] m);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = int'(ATOMS) - 1; i >= 0; i--) begin
         if (m[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/nv_nvdla_sdp_rdma_eg_cnt.sv
// Three-level cube position counter (width, height, surface) with look-ahead last flags.
module nv_nvdla_sdp_rdma_eg_cnt
   import nv_nvdla_sdp_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] width_i,
   input  logic [CNT_W-1:0] height_i,
   input  logic [CNT_W-1:0] surf_i,
   input  logic             step_i,
   output logic             nxt_last_w_o,
   output logic             nxt_last_h_o,
   output logic             nxt_last_c_o
);

   logic [CNT_W-1:0] cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d, cfg_s_q, cfg_s_d;
   logic [CNT_W-1:0] w_q, w_d, h_q, h_d, s_q, s_d;

   always_comb begin
      cfg_w_d = cfg_w_q;
      cfg_h_d = cfg_h_q;
      cfg_s_d = cfg_s_q;
      w_d     = w_q;
      h_d     = h_q;
      s_d     = s_q;
      if (clr_i) begin
         cfg_w_d = width_i;
         cfg_h_d = height_i;
         cfg_s_d = surf_i;
         w_d     = '0;
         h_d     = '0;
         s_d     = '0;
      end else if (step_i) begin
         if (w_q == cfg_w_q) begin
            w_d = '0;
            if (h_q == cfg_h_q) begin
               h_d = '0;
               s_d = (s_q == cfg_s_q) ? '0 : s_q + CNT_W'(1);
            end else begin
               h_d = h_q + CNT_W'(1);
            end
         end else begin
            w_d = w_q + CNT_W'(1);
         end
      end
   end

   // Flags describe the position the counters hold after this cycle, i.e. the next atom presented.
   assign nxt_last_w_o = (w_d == cfg_w_d);
   assign nxt_last_h_o = nxt_last_w_o && (h_d == cfg_h_d);
   assign nxt_last_c_o = nxt_last_h_o && (s_d == cfg_s_d);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_w_q <= '0;
         cfg_h_q <= '0;
         cfg_s_q <= '0;
         w_q     <= '0;
         h_q     <= '0;
         s_q     <= '0;
      end else begin
         cfg_w_q <= cfg_w_d;
         cfg_h_q <= cfg_h_d;
         cfg_s_q <= cfg_s_d;
         w_q     <= w_d;
         h_q     <= h_d;
         s_q     <= s_d;
      end
   end

endmodule

// File: rtl/nv_nvdla_sdp_rdma_eg.sv
// SDP RDMA egress: serialises masked packed words into tagged 64-bit atoms and tracks cube completion.
module nv_nvdla_sdp_rdma_eg
   import nv_nvdla_sdp_pkg::*;
(
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rst,
   input  logic              reg2dp_op_en,
   input  logic [CNT_W-1:0]  reg2dp_width,
   input  logic [CNT_W-1:0]  reg2dp_height,
   input  logic [CNT_W-1:0]  reg2dp_surf,
   input  logic              inp_pvld,
   output logic              inp_prdy,
   input  logic [IN_W-1:0]   inp_data,
   output logic              out_pvld,
   input  logic              out_prdy,
   output logic [ATOM_W-1:0] out_data,
   output logic              out_last_w,
   output logic              out_last_h,
   output logic              out_last_c,
   output logic              layer_done,
   output logic              eg_err
);

   eg_state_t           state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ATOMS-1:0]    rem_q, rem_d;
   logic                pvld_q, pvld_d;
   logic [ATOM_W-1:0]   odata_q, odata_d;
   logic                lw_q, lw_d, lh_q, lh_d, lc_q, lc_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [ATOMS-1:0]    in_mask;
   logic [DATA_W-1:0]   in_atoms;
   logic                out_hs, in_hs, cnt_clr;
   logic                nxt_lw, nxt_lh, nxt_lc;
   logic                present;
   logic [ATOMS-1:0]    src_mask;
   logic [DATA_W-1:0]   src_atoms;
   logic [IDX_W-1:0]    sel_idx;

   assign in_mask  = inp_data[IN_W-1 -: ATOMS];
   assign in_atoms = inp_data[DATA_W-1:0];
   assign out_hs   = pvld_q && out_prdy;
   assign cnt_clr  = (state_q == IDLE) && reg2dp_op_en;

   // The holding slot frees when its final atom drains; nothing new is taken once the cube ends.
   assign inp_prdy = (state_q == RUN) && !(out_hs && lc_q) &&
                     (!pvld_q || (out_hs && (rem_q == '0)));
   assign in_hs    = inp_pvld && inp_prdy;

   nv_nvdla_sdp_rdma_eg_cnt u_cnt (
      .clk_i        (nvdla_core_clk),
      .rst_i        (nvdla_core_rst),
      .clr_i        (cnt_clr),
      .width_i      (reg2dp_width),
      .height_i     (reg2dp_height),
      .surf_i       (reg2dp_surf),
      .step_i       (out_hs),
      .nxt_last_w_o (nxt_lw),
      .nxt_last_h_o (nxt_lh),
      .nxt_last_c_o (nxt_lc)
   );

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      rem_d     = rem_q;
      pvld_d    = pvld_q;
      odata_d   = odata_q;
      lw_d      = lw_q;
      lh_d      = lh_q;
      lc_d      = lc_q;
      done_d    = 1'b0;
      err_d     = err_q;
      present   = 1'b0;
      src_mask  = '0;
      src_atoms = data_q;
      sel_idx   = '0;

      case (state_q)
         IDLE: begin
            if (reg2dp_op_en) begin
               err_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (out_hs) begin
               pvld_d = 1'b0;
               lw_d   = 1'b0;
               lh_d   = 1'b0;
               lc_d   = 1'b0;
               if (lc_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  rem_d   = '0;
                  if (rem_q != '0) err_d = 1'b1;
               end else if (rem_q != '0) begin
                  present  = 1'b1;
                  src_mask = rem_q;
               end
            end
            if (in_hs) begin
               data_d = in_atoms;
               if (mask_legal(in_mask)) begin
                  present   = 1'b1;
                  src_mask  = in_mask;
                  src_atoms = in_atoms;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (present) begin
         sel_idx = lsb_idx(src_mask);
         pvld_d  = 1'b1;
         odata_d = src_atoms[int'(sel_idx)*ATOM_W +: ATOM_W];
         rem_d   = src_mask & ~(ATOMS'(1) << sel_idx);
         lw_d    = nxt_lw;
         lh_d    = nxt_lh;
         lc_d    = nxt_lc;
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         pvld_q  <= 1'b0;
         odata_q <= '0;
         lw_q    <= 1'b0;
         lh_q    <= 1'b0;
         lc_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         pvld_q  <= pvld_d;
         odata_q <= odata_d;
         lw_q    <= lw_d;
         lh_q    <= lh_d;
         lc_q    <= lc_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign out_pvld   = pvld_q;
   assign out_data   = odata_q;
   assign out_last_w = lw_q;
   assign out_last_h = lh_q;
   assign out_last_c = lc_q;
   assign layer_done = done_q;
   assign eg_err     = err_q;

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_eg.sv
// Directed self-checking bench for the SDP RDMA egress stage.
module tb_nv_nvdla_sdp_rdma_eg;
   import nv_nvdla_sdp_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              op_en;
   logic [CNT_W-1:0]  cfg_w, cfg_h, cfg_s;
   logic              inp_pvld, inp_prdy;
   logic [IN_W-1:0]   inp_data;
   logic              out_pvld, out_prdy;
   logic [ATOM_W-1:0] out_data;
   logic              out_last_w, out_last_h, out_last_c;
   logic              layer_done, eg_err;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   logic [ATOM_W-1:0] mon_data[$];

   always #5 clk = ~clk;

   nv_nvdla_sdp_rdma_eg dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .reg2dp_op_en   (op_en),
      .reg2dp_width   (cfg_w),
      .reg2dp_height  (cfg_h),
      .reg2dp_surf    (cfg_s),
      .inp_pvld       (inp_pvld),
      .inp_prdy       (inp_prdy),
      .inp_data       (inp_data),
      .out_pvld       (out_pvld),
      .out_prdy       (out_prdy),
      .out_data       (out_data),
      .out_last_w     (out_last_w),
      .out_last_h     (out_last_h),
      .out_last_c     (out_last_c),
      .layer_done     (layer_done),
      .eg_err         (eg_err)
   );

   always @(posedge clk) begin
      if (!rst && out_pvld && out_prdy) mon_data.push_back(out_data);
      if (!rst && layer_done) done_cnt++;
   end

   function automatic logic [ATOM_W-1:0] atom(input int tag, input int i);
      return {32'hC0DE_0000 | 32'(tag), 32'(i)};
   endfunction

   function automatic logic [IN_W-1:0] word(input int tag, input logic [ATOMS-1:0] m);
      logic [IN_W-1:0] w;
      w = '0;
      w[IN_W-1 -: ATOMS] = m;
      for (int i = 0; i < int'(ATOMS); i++) w[i*ATOM_W +: ATOM_W] = atom(tag, i);
      return w;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int w, input int h, input int s);
      cfg_w = CNT_W'(w); cfg_h = CNT_W'(h); cfg_s = CNT_W'(s);
      op_en = 1'b1;
      cyc();
      op_en = 1'b0;
      mon_data.delete();
      done_cnt = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; op_en = 1'b0; inp_pvld = 1'b0; inp_data = '0; out_prdy = 1'b1;
      cfg_w = '0; cfg_h = '0; cfg_s = '0;
      cyc(); cyc();
      checks++;
      if ({out_pvld, inp_prdy, layer_done, eg_err, out_last_w, out_last_h, out_last_c} !== 7'b0 || out_data !== '0) begin
         failures++;
         $display("FAIL reset got pvld=%b prdy=%b done=%b err=%b flags=%b%b%b data=%h exp all 0",
                  out_pvld, inp_prdy, layer_done, eg_err, out_last_w, out_last_h, out_last_c, out_data);
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_single_word();
      logic [2:0] ef;
      start(3, 0, 0);
      checks++;
      if (eg_err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", eg_err); end
      inp_pvld = 1'b1; inp_data = word(1, 4'hF);
      checks++;
      if (inp_prdy !== 1'b1) begin failures++; $display("FAIL single_prdy got=%b exp=1", inp_prdy); end
      cyc();
      inp_pvld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ef = (i == 3) ? 3'b111 : 3'b000;
         checks++;
         if ({out_pvld, out_data, out_last_w, out_last_h, out_last_c, layer_done} !== {1'b1, atom(1, i), ef, 1'b0}) begin
            failures++;
            $display("FAIL single_atom%0d got v=%b d=%h f=%b%b%b done=%b exp d=%h f=%b done=0",
                     i, out_pvld, out_data, out_last_w, out_last_h, out_last_c, layer_done, atom(1, i), ef);
         end
         cyc();
      end
      checks++;
      if (layer_done !== 1'b1 || out_pvld !== 1'b0) begin
         failures++; $display("FAIL single_done got done=%b pvld=%b exp done=1 pvld=0", layer_done, out_pvld);
      end
      cyc();
      checks++;
      if (layer_done !== 1'b0 || done_cnt !== 1 || mon_data.size() !== 4) begin
         failures++;
         $display("FAIL single_pulse got done=%b cnt=%0d atoms=%0d exp 0 1 4", layer_done, done_cnt, mon_data.size());
      end
   endtask

   task automatic test_two_lines();
      logic [ATOM_W-1:0] ed [4];
      logic [2:0]        ef [4];
      ed[0] = atom(2, 0); ed[1] = atom(2, 1); ed[2] = atom(3, 0); ed[3] = atom(3, 1);
      ef[0] = 3'b000; ef[1] = 3'b100; ef[2] = 3'b000; ef[3] = 3'b111;
      start(1, 1, 0);
      inp_pvld = 1'b1; inp_data = word(2, 4'h3);
      cyc();
      inp_data = word(3, 4'h3);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({out_pvld, out_data, out_last_w, out_last_h, out_last_c} !== {1'b1, ed[k], ef[k]}) begin
            failures++;
            $display("FAIL two_lines_atom%0d got v=%b d=%h f=%b%b%b exp v=1 d=%h f=%b",
                     k, out_pvld, out_data, out_last_w, out_last_h, out_last_c, ed[k], ef[k]);
         end
         if (k < 2) begin
            checks++;
            if (inp_prdy !== (k == 1)) begin
               failures++; $display("FAIL two_lines_prdy%0d got=%b exp=%b", k, inp_prdy, (k == 1));
            end
         end
         cyc();
         if (k == 1) inp_pvld = 1'b0;
      end
      checks++;
      if (layer_done !== 1'b1) begin failures++; $display("FAIL two_lines_done got=%b exp=1", layer_done); end
      cyc();
   endtask

   task automatic test_stall();
      start(2, 0, 0);
      out_prdy = 1'b1;
      inp_pvld = 1'b1; inp_data = word(4, 4'h7);
      cyc();
      inp_pvld = 1'b0;
      checks++;
      if (out_pvld !== 1'b1 || out_data !== atom(4, 0)) begin
         failures++; $display("FAIL stall_a0 got v=%b d=%h exp v=1 d=%h", out_pvld, out_data, atom(4, 0));
      end
      cyc();
      out_prdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_pvld !== 1'b1 || out_data !== atom(4, 1) || out_last_c !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold%0d got v=%b d=%h lc=%b exp v=1 d=%h lc=0", k, out_pvld, out_data, out_last_c, atom(4, 1));
         end
         if (k == 2) out_prdy = 1'b1;
         else cyc();
      end
      cyc();
      checks++;
      if (out_pvld !== 1'b1 || out_data !== atom(4, 2) || out_last_c !== 1'b1) begin
         failures++; $display("FAIL stall_a2 got v=%b d=%h lc=%b exp v=1 d=%h lc=1", out_pvld, out_data, out_last_c, atom(4, 2));
      end
      cyc(); cyc();
      checks++;
      if (mon_data.size() !== 3 || done_cnt !== 1) begin
         failures++; $display("FAIL stall_count got atoms=%0d done=%0d exp 3 1", mon_data.size(), done_cnt);
      end
      for (int k = 0; k < 3 && k < mon_data.size(); k++) begin
         checks++;
         if (mon_data[k] !== atom(4, k)) begin
            failures++; $display("FAIL stall_seq%0d got=%h exp=%h", k, mon_data[k], atom(4, k));
         end
      end
   endtask

   task automatic test_bad_mask();
      start(3, 0, 0);
      inp_pvld = 1'b1; inp_data = word(5, 4'h5);
      cyc();
      checks++;
      if (out_pvld !== 1'b0 || eg_err !== 1'b1 || inp_prdy !== 1'b1) begin
         failures++; $display("FAIL bad_mask got v=%b err=%b prdy=%b exp 0 1 1", out_pvld, eg_err, inp_prdy);
      end
      inp_data = word(6, 4'hF);
      cyc();
      inp_pvld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_pvld !== 1'b1 || out_data !== atom(6, i) || out_last_c !== (i == 3)) begin
            failures++;
            $display("FAIL bad_next_atom%0d got v=%b d=%h lc=%b exp v=1 d=%h lc=%b", i, out_pvld, out_data, out_last_c, atom(6, i), (i == 3));
         end
         cyc();
      end
      checks++;
      if (layer_done !== 1'b1 || eg_err !== 1'b1 || mon_data.size() !== 4) begin
         failures++; $display("FAIL bad_end got done=%b err=%b atoms=%0d exp 1 1 4", layer_done, eg_err, mon_data.size());
      end
      cyc();
   endtask

   task automatic test_leftover();
      start(1, 0, 0);
      checks++;
      if (eg_err !== 1'b0) begin failures++; $display("FAIL leftover_clr got err=%b exp=0", eg_err); end
      inp_pvld = 1'b1; inp_data = word(7, 4'hF);
      cyc();
      inp_pvld = 1'b0;
      cyc();
      checks++;
      if (out_data !== atom(7, 1) || {out_last_w, out_last_h, out_last_c} !== 3'b111) begin
         failures++; $display("FAIL leftover_a1 got d=%h f=%b%b%b exp d=%h f=111", out_data, out_last_w, out_last_h, out_last_c, atom(7, 1));
      end
      cyc();
      checks++;
      if (layer_done !== 1'b1 || eg_err !== 1'b1 || out_pvld !== 1'b0 || mon_data.size() !== 2) begin
         failures++;
         $display("FAIL leftover_end got done=%b err=%b v=%b atoms=%0d exp 1 1 0 2", layer_done, eg_err, out_pvld, mon_data.size());
      end
      cyc();
   endtask

   task automatic test_reset_mid();
      start(3, 0, 0);
      inp_pvld = 1'b1; inp_data = word(8, 4'hF);
      cyc();
      inp_pvld = 1'b0;
      cyc(); cyc();
      checks++;
      if (out_data !== atom(8, 2)) begin failures++; $display("FAIL rmid_pre got d=%h exp=%h", out_data, atom(8, 2)); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if (out_pvld !== 1'b0 || inp_prdy !== 1'b0 || out_data !== '0 || layer_done !== 1'b0) begin
         failures++; $display("FAIL rmid_reset got v=%b prdy=%b d=%h done=%b exp 0 0 0 0", out_pvld, inp_prdy, out_data, layer_done);
      end
      inp_pvld = 1'b1; inp_data = word(9, 4'hF);
      cyc();
      checks++;
      if (out_pvld !== 1'b0 || mon_data.size() !== 2) begin
         failures++; $display("FAIL rmid_idle got v=%b atoms=%0d exp 0 2", out_pvld, mon_data.size());
      end
      inp_pvld = 1'b0;
      start(3, 0, 0);
      inp_pvld = 1'b1; inp_data = word(10, 4'hF);
      cyc();
      inp_pvld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_pvld !== 1'b1 || out_data !== atom(10, i) || out_last_c !== (i == 3)) begin
            failures++;
            $display("FAIL rmid_atom%0d got v=%b d=%h lc=%b exp v=1 d=%h lc=%b", i, out_pvld, out_data, out_last_c, atom(10, i), (i == 3));
         end
         cyc();
      end
      cyc();
      checks++;
      if (done_cnt !== 1 || eg_err !== 1'b0) begin
         failures++; $display("FAIL rmid_done got done=%0d err=%b exp 1 0", done_cnt, eg_err);
      end
   endtask

   task automatic test_op_en_in_run();
      logic [2:0] ef [4];
      ef[0] = 3'b000; ef[1] = 3'b110; ef[2] = 3'b000; ef[3] = 3'b111;
      start(1, 0, 1);
      inp_pvld = 1'b1; inp_data = word(11, 4'h3);
      cyc();
      inp_data = word(12, 4'h3);
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin op_en = 1'b1; cfg_w = '0; end
         if (k == 1) op_en = 1'b0;
         checks++;
         if ({out_pvld, out_data, out_last_w, out_last_h, out_last_c} !== {1'b1, atom(11 + k / 2, k % 2), ef[k]}) begin
            failures++;
            $display("FAIL open_atom%0d got v=%b d=%h f=%b%b%b exp v=1 d=%h f=%b",
                     k, out_pvld, out_data, out_last_w, out_last_h, out_last_c, atom(11 + k / 2, k % 2), ef[k]);
         end
         cyc();
         if (k == 1) inp_pvld = 1'b0;
      end
      checks++;
      if (layer_done !== 1'b1) begin failures++; $display("FAIL open_done got=%b exp=1", layer_done); end
      cyc(); cyc(); cyc();
      checks++;
      if (done_cnt !== 1 || layer_done !== 1'b0 || mon_data.size() !== 4) begin
         failures++;
         $display("FAIL open_once got cnt=%0d done=%b atoms=%0d exp 1 0 4", done_cnt, layer_done, mon_data.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_two_lines();
      test_stall();
      test_bad_mask();
      test_leftover();
      test_reset_mid();
      test_op_en_in_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
